// File: rtl/fifo_ctrl_pkg.sv
// Shared types and defaults for the 8-entry FIFO sequencing controller.
// The state encoding and the ack/err decode live here so the bench and RTL agree on names.
package fifo_ctrl_pkg;

  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned AW_DEF    = 3;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    WR_RD,
    WR_ERR,
    RD_ERR,
    WR_RD_ERR
  } state_e;

  typedef struct packed {
    logic wr_ack;
    logic wr_err;
    logic rd_ack;
    logic rd_err;
  } resp_t;

  // WR_RD_ERR covers both the full case (read done) and the empty case (write done);
  // wr_done selects which half of the response is an ack.
  function automatic resp_t state_resp(input state_e st, input logic wr_done);
    resp_t r;
    r = '0;
    unique case (st)
      WRITE:     r.wr_ack = 1'b1;
      READ:      r.rd_ack = 1'b1;
      WR_RD: begin
        r.wr_ack = 1'b1;
        r.rd_ack = 1'b1;
      end
      WR_ERR:    r.wr_err = 1'b1;
      RD_ERR:    r.rd_err = 1'b1;
      WR_RD_ERR: begin
        r.wr_ack = wr_done;
        r.rd_err = wr_done;
        r.wr_err = ~wr_done;
        r.rd_ack = ~wr_done;
      end
      default:   r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fifo_ctrl_onehot_decoder.sv
// Binary-to-one-hot decoder with enable; drives the FIFO entry write strobes.
module onehot_decoder
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned N  = DEPTH_DEF
) (
  input  logic [AW-1:0] sel_i,
  input  logic          en_i,
  output logic [N-1:0]  onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/count/status sequencer for an external 8x32 register FIFO and its read mux.
// Pops capture the muxed head word into d_out; a small FSM reports per-request ack/err.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [DW-1:0]    mux_data,
  output logic [AW-1:0]    rd_addr,
  output logic [DEPTH-1:0] we,
  output logic [DW-1:0]    d_out,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      data_count,
  output logic             wr_ack,
  output logic             wr_err,
  output logic             rd_ack,
  output logic             rd_err
);

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic [DW-1:0] dout_q, dout_d;
  state_e        state_q, state_d;
  resp_t         resp_q;
  logic          wr_ok, rd_ok;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  onehot_decoder #(
    .AW (AW),
    .N  (DEPTH)
  ) u_we_dec (
    .sel_i    (tail_q),
    .en_i     (wr_ok),
    .onehot_o (we)
  );

  // Pointers wrap naturally at AW bits because DEPTH is a power of two.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    dout_d  = dout_q;
    if (rd_ok) begin
      head_d = head_q + AW'(1);
      dout_d = mux_data;
    end
    if (wr_ok) begin
      tail_d = tail_q + AW'(1);
    end
    if (wr_ok && !rd_ok) begin
      count_d = count_q + (AW+1)'(1);
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

  // A request can only be rejected for full (write) or empty (read); both at once cannot occur.
  always_comb begin
    state_d = IDLE;
    if (wr_ok && rd_ok) begin
      state_d = WR_RD;
    end else if (wr_ok) begin
      state_d = rd_en ? WR_RD_ERR : WRITE;
    end else if (rd_ok) begin
      state_d = wr_en ? WR_RD_ERR : READ;
    end else if (wr_en) begin
      state_d = WR_ERR;
    end else if (rd_en) begin
      state_d = RD_ERR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      resp_q  <= state_resp(state_d, wr_ok);
    end
  end

  assign rd_addr    = head_q;
  assign d_out      = dout_q;
  assign data_count = count_q;
  assign wr_ack     = resp_q.wr_ack;
  assign wr_err     = resp_q.wr_err;
  assign rd_ack     = resp_q.rd_ack;
  assign rd_err     = resp_q.rd_err;

endmodule
